// File: rtl/lfsr_checker_if.sv
// Bundle between an LFSR pattern source and the lfsr_checker.
// The source drives valid/data/clear; the checker returns its status.
interface lfsr_checker_if #(
    parameter int ERR_W = 8
);
    logic             valid;
    logic [3:0]       data;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       expected;
    logic             zero_seen;

    modport master (
        output valid, data, clear,
        input  locked, err_pulse, err_count,
        input  expected, zero_seen
    );

    modport slave (
        input  valid, data, clear,
        output locked, err_pulse, err_count,
        output expected, zero_seen
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the x^4+x^3+1 pattern stream.
// Locks after LOCK_COUNT in-sequence words, then flywheels and counts errors.
module lfsr_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input logic           clk,
    input logic           reset,
    lfsr_checker_if.slave bus
);
    localparam logic [0:0] SYNC   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [3:0]       exp_q, exp_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             pulse_q, pulse_d;

    logic [3:0] run_inc;
    logic [3:0] miss_inc;
    logic       is_zero;
    logic       hit;

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;
    assign is_zero  = (bus.data == 4'b0000);
    assign hit      = (bus.data == exp_q);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        miss_d  = miss_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        pulse_d = 1'b0;
        if (bus.valid) begin
            unique case (state_q)
                SYNC: begin
                    if (is_zero) begin
                        zero_d = 1'b1;
                        run_d  = 4'd0;
                    end else if (run_q != 4'd0 && hit) begin
                        run_d = run_inc;
                        exp_d = nxt(bus.data);
                        if (run_inc == 4'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        exp_d = nxt(bus.data);
                        run_d = 4'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances regardless of data.
                    exp_d = nxt(exp_q);
                    if (hit) begin
                        miss_d = 4'd0;
                    end else begin
                        pulse_d = 1'b1;
                        miss_d  = miss_inc;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                        if (is_zero) begin
                            zero_d = 1'b1;
                        end
                        if (miss_inc == 4'(LOSS_COUNT)) begin
                            state_d = SYNC;
                            run_d   = 4'd0;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end
        if (bus.clear) begin
            cnt_d  = '0;
            zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SYNC;
            run_q   <= 4'd0;
            miss_q  <= 4'd0;
            exp_q   <= 4'd0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = cnt_q;
    assign bus.expected  = exp_q;
    assign bus.zero_seen = zero_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (LOSS_COUNT 2 and 15) share one
// stimulus stream and are compared against a sequence-table model.
module tb_lfsr_checker;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lfsr_checker_if #(.ERR_W(8)) b1 ();
    lfsr_checker_if #(.ERR_W(8)) b2 ();

    lfsr_checker #(.LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_W(8)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    lfsr_checker #(.LOCK_COUNT(3), .LOSS_COUNT(15), .ERR_W(8)) u2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         lk;
        int         run;
        int         miss;
        logic [3:0] ex;
        int         cnt;
        bit         zs;
        bit         pulse;
    } mdl_t;

    // The full period-15 sequence starting at 1111.
    logic [3:0] seq [15] = '{
        4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001,
        4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
        4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111
    };

    mdl_t m1, m2;
    int   gi;

    function automatic logic [3:0] succ(input logic [3:0] x);
        for (int i = 0; i < 15; i++)
            if (seq[i] == x) return seq[(i + 1) % 15];
        return 4'b0000;
    endfunction

    function automatic mdl_t rst_mdl();
        mdl_t n;
        n.lk = 0; n.run = 0; n.miss = 0; n.ex = 4'b0000;
        n.cnt = 0; n.zs = 0; n.pulse = 0;
        return n;
    endfunction

    function automatic mdl_t step(mdl_t m, int lockc, int lossc,
                                  bit rn, bit v, logic [3:0] d, bit c);
        mdl_t n = m;
        n.pulse = 0;
        if (!rn) return rst_mdl();
        if (v && !m.lk) begin
            if (d == 4'b0000) begin
                n.zs = 1;
                n.run = 0;
            end else begin
                n.ex = succ(d);
                n.run = (m.run > 0 && d == m.ex) ? m.run + 1 : 1;
                if (n.run == lockc) begin
                    n.lk = 1;
                    n.miss = 0;
                end
            end
        end else if (v) begin
            n.ex = succ(m.ex);
            if (d == m.ex) begin
                n.miss = 0;
            end else begin
                n.pulse = 1;
                n.cnt = (m.cnt + 1 > 255) ? 255 : m.cnt + 1;
                n.miss = m.miss + 1;
                if (d == 4'b0000) n.zs = 1;
                if (n.miss == lossc) begin
                    n.lk = 0;
                    n.run = 0;
                end
            end
        end
        if (c) begin
            n.cnt = 0;
            n.zs = 0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d1.locked", int'(b1.locked), int'(m1.lk));
        chk("d1.pulse", int'(b1.err_pulse), int'(m1.pulse));
        chk("d1.count", int'(b1.err_count), m1.cnt);
        chk("d1.expected", int'(b1.expected), int'(m1.ex));
        chk("d1.zero", int'(b1.zero_seen), int'(m1.zs));
        chk("d2.locked", int'(b2.locked), int'(m2.lk));
        chk("d2.pulse", int'(b2.err_pulse), int'(m2.pulse));
        chk("d2.count", int'(b2.err_count), m2.cnt);
        chk("d2.expected", int'(b2.expected), int'(m2.ex));
        chk("d2.zero", int'(b2.zero_seen), int'(m2.zs));
    endtask

    task automatic cycle(input bit rn, input bit v,
                         input logic [3:0] d, input bit c);
        @(negedge clk);
        reset = rn;
        b1.valid = v; b1.data = d; b1.clear = c;
        b2.valid = v; b2.data = d; b2.clear = c;
        m1 = step(m1, 3, 2, rn, v, d, c);
        m2 = step(m2, 3, 15, rn, v, d, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic good();
        cycle(1, 1, seq[gi], 0);
        gi = (gi + 1) % 15;
    endtask

    task automatic bad(input logic [3:0] x, input bit c);
        cycle(1, 1, seq[gi] ^ x, c);
        gi = (gi + 1) % 15;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        gi = 0;
        m1 = rst_mdl();
        m2 = rst_mdl();
        reset = 0;
        b1.valid = 0; b1.data = 0; b1.clear = 0;
        b2.valid = 0; b2.data = 0; b2.clear = 0;

        cycle(0, 0, 4'b0000, 0);
        cycle(0, 0, 4'b0000, 0);
        chk("rst.locked", int'(b1.locked), 0);
        chk("rst.expected", int'(b1.expected), 0);

        repeat (3) good();
        chk("lock.d1", int'(b1.locked), 1);
        chk("lock.d2", int'(b2.locked), 1);
        chk("lock.expected", int'(b1.expected), 4'b1000);
        repeat (30) good();
        chk("lock.clean", int'(b1.err_count), 0);

        while (seq[gi] != 4'b1001) good();
        bad(4'b0010, 0);
        chk("single.pulse", int'(b1.err_pulse), 1);
        chk("single.count", int'(b1.err_count), 1);
        chk("single.locked", int'(b1.locked), 1);
        good();
        chk("single.next", int'(b1.err_pulse), 0);
        chk("single.hold", int'(b1.err_count), 1);

        cycle(1, 0, 4'b0000, 1);
        bad(4'b0110, 0);
        chk("loss.first", int'(b1.locked), 1);
        bad(4'b0110, 0);
        chk("loss.second", int'(b1.locked), 0);
        chk("loss.count", int'(b1.err_count), 2);
        chk("loss.d2", int'(b2.locked), 1);
        repeat (2) good();
        chk("relock.early", int'(b1.locked), 0);
        good();
        chk("relock.d1", int'(b1.locked), 1);

        repeat (10) begin
            cycle(1, 0, 4'($urandom_range(0, 15)), 0);
            good();
        end
        chk("gap.count", int'(b1.err_count), 2);
        chk("gap.locked", int'(b1.locked), 1);

        cycle(0, 1, seq[gi], 0);
        chk("rst.mid.locked", int'(b1.locked), 0);
        chk("rst.mid.count", int'(b1.err_count), 0);
        chk("rst.mid.expected", int'(b1.expected), 0);

        cycle(1, 1, 4'b0000, 0);
        chk("zero.sync", int'(b1.zero_seen), 1);
        chk("zero.locked", int'(b1.locked), 0);

        repeat (3) good();
        chk("sat.lock", int'(b2.locked), 1);
        repeat (22) begin
            repeat (14) bad(4'b0110, 0);
            good();
        end
        chk("sat.count", int'(b2.err_count), 255);
        chk("sat.locked", int'(b2.locked), 1);
        bad(4'b0110, 1);
        chk("clear.count", int'(b2.err_count), 0);
        chk("clear.pulse", int'(b2.err_pulse), 1);

        repeat (500) begin
            bit         rn, v, c;
            logic [3:0] d;
            rn = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 19) == 0);
            d  = ($urandom_range(0, 9) < 7) ? seq[gi]
                                             : 4'($urandom_range(0, 15));
            cycle(rn, v, d, c);
            if (v) gi = (gi + 1) % 15;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
